// File: rtl/redirect_ctrl.sv
// redirect_ctrl: control-flow redirect controller for the RISC-V pipeline.
// Arbitrates taken-branch / JAL / JALR requests into a registered next-PC
// select, redirect target and per-stage flush strobes. Redirects requested
// under a stall are held and issued once the stall clears; after each issue
// a shadow window drops requests coming from wrong-path instructions.
// Optional feature: define BRANCH_STATS_EN to add saturating counters of
// issued and deferred redirects (stat_redir_o / stat_defer_o).
module redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_STAGES = 2,
    parameter int SHADOW_CYC   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    branch_i,
    input  logic [XLEN-1:0]         branch_tgt_i,
    input  logic [1:0]              jump_i,
    input  logic [XLEN-1:0]         jal_tgt_i,
    input  logic [XLEN-1:0]         jalr_tgt_i,
    output logic [1:0]              pc_sel_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    output logic                    redirect_vld_o,
    output logic [FLUSH_STAGES-1:0] flush_o,
    output logic                    busy_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]        stat_redir_o,
    output logic [CNT_W-1:0]        stat_defer_o
`endif
);

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_TGT  = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;
    localparam logic [3:0] SHADOW_LD = 4'(SHADOW_CYC);

    // Elaboration-time legality checks on the configuration.
    if (FLUSH_STAGES < 1 || FLUSH_STAGES > 4) begin : g_bad_flush
        $error("redirect_ctrl: FLUSH_STAGES must be 1..4");
    end
    if (SHADOW_CYC < 0 || SHADOW_CYC > 15) begin : g_bad_shadow
        $error("redirect_ctrl: SHADOW_CYC must be 0..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("redirect_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SHADOW  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        shadow_cnt;
    logic [3:0]        shadow_cnt_nxt;

    // Stage p0: request decode and issue decision (combinational)
    logic              req_p0;
    logic [1:0]        sel_p0;
    logic [XLEN-1:0]   tgt_p0;
    logic              issue_p0;
    logic [1:0]        iss_sel_p0;
    logic [XLEN-1:0]   iss_tgt_p0;

    // Request captured while the pipeline is stalled
    logic [1:0]        pend_sel;
    logic [XLEN-1:0]   pend_tgt;

    // Stage p1: registered outputs
    logic              vld_p1;
    logic [1:0]        sel_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [FLUSH_STAGES-1:0] flush_p1;
    logic              busy_p1;

    // Priority: branch > JALR > JAL; jump_i = 11 counts as no request.
    always_comb begin
        req_p0 = 1'b1;
        sel_p0 = SEL_PC4;
        tgt_p0 = '0;
        if (branch_i) begin
            sel_p0 = SEL_TGT;
            tgt_p0 = branch_tgt_i;
        end else if (jump_i == 2'b10) begin
            sel_p0 = SEL_JALR;
            tgt_p0 = jalr_tgt_i;
        end else if (jump_i == 2'b01) begin
            sel_p0 = SEL_TGT;
            tgt_p0 = jal_tgt_i;
        end else begin
            req_p0 = 1'b0;
        end
    end

    // Next-state logic: decides whether this edge issues and where the FSM goes.
    always_comb begin
        state_nxt      = state;
        shadow_cnt_nxt = shadow_cnt;
        issue_p0       = 1'b0;
        iss_sel_p0     = sel_p0;
        iss_tgt_p0     = tgt_p0;
        case (state)
            IDLE: begin
                if (req_p0) begin
                    if (stall_i) begin
                        state_nxt = PENDING;
                    end else begin
                        issue_p0 = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (!stall_i) begin
                    issue_p0   = 1'b1;
                    iss_sel_p0 = pend_sel;
                    iss_tgt_p0 = pend_tgt;
                end
            end
            SHADOW: begin
                // The exit edge is unconditional; only the countdown waits on stalls.
                if (shadow_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else if (!stall_i) begin
                    shadow_cnt_nxt = shadow_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (issue_p0) begin
            if (SHADOW_CYC == 0) begin
                state_nxt      = IDLE;
                shadow_cnt_nxt = 4'd0;
            end else begin
                state_nxt      = SHADOW;
                shadow_cnt_nxt = SHADOW_LD;
            end
        end
    end

    // Capture the winning request on entry to PENDING (data path, no reset).
    always_ff @(posedge clock) begin
        if (state == IDLE && req_p0 && stall_i) begin
            pend_sel <= sel_p0;
            pend_tgt <= tgt_p0;
        end
    end

    // Stage p0 -> p1: FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shadow_cnt <= 4'd0;
            vld_p1     <= 1'b0;
            sel_p1     <= SEL_PC4;
            pc_p1      <= '0;
            flush_p1   <= '0;
            busy_p1    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow_cnt <= shadow_cnt_nxt;
            vld_p1     <= issue_p0;
            sel_p1     <= issue_p0 ? iss_sel_p0 : SEL_PC4;
            pc_p1      <= issue_p0 ? iss_tgt_p0 : '0;
            flush_p1   <= {FLUSH_STAGES{issue_p0}};
            busy_p1    <= (state_nxt != IDLE);
        end
    end

    assign redirect_vld_o = vld_p1;
    assign pc_sel_o       = sel_p1;
    assign redirect_pc_o  = pc_p1;
    assign flush_o        = flush_p1;
    assign busy_o         = busy_p1;

`ifdef BRANCH_STATS_EN
    logic defer_p0;
    assign defer_p0 = (state == IDLE) && req_p0 && stall_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating counters of issued and stall-deferred redirects
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_redir_o <= '0;
            stat_defer_o <= '0;
        end else begin
            if (issue_p0) stat_redir_o <= sat_inc(stat_redir_o);
            if (defer_p0) stat_defer_o <= sat_inc(stat_defer_o);
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: two instances (shadow window 2 / 16-bit stats,
// and shadow window 0 / 2-bit stats) driven by the same stimulus and compared
// every cycle against a transaction-level reference model.
module tb_redirect_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, stall_i, branch_i;
    logic [31:0] branch_tgt_i, jal_tgt_i, jalr_tgt_i;
    logic [1:0]  jump_i;

    logic [1:0]  a_sel, b_sel;
    logic [31:0] a_pc, b_pc;
    logic        a_vld, b_vld, a_busy, b_busy;
    logic [1:0]  a_flush;
    logic [2:0]  b_flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] a_sredir, a_sdefer;
    logic [1:0]  b_sredir, b_sdefer;
`endif

    redirect_ctrl #(.XLEN(32), .FLUSH_STAGES(2), .SHADOW_CYC(2), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
        .branch_tgt_i(branch_tgt_i), .jump_i(jump_i), .jal_tgt_i(jal_tgt_i),
        .jalr_tgt_i(jalr_tgt_i), .pc_sel_o(a_sel), .redirect_pc_o(a_pc),
        .redirect_vld_o(a_vld), .flush_o(a_flush), .busy_o(a_busy)
`ifdef BRANCH_STATS_EN
        , .stat_redir_o(a_sredir), .stat_defer_o(a_sdefer)
`endif
    );

    redirect_ctrl #(.XLEN(32), .FLUSH_STAGES(3), .SHADOW_CYC(0), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
        .branch_tgt_i(branch_tgt_i), .jump_i(jump_i), .jal_tgt_i(jal_tgt_i),
        .jalr_tgt_i(jalr_tgt_i), .pc_sel_o(b_sel), .redirect_pc_o(b_pc),
        .redirect_vld_o(b_vld), .flush_o(b_flush), .busy_o(b_busy)
`ifdef BRANCH_STATS_EN
        , .stat_redir_o(b_sredir), .stat_defer_o(b_sdefer)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: "quiet" counts the remaining edges on which requests are
    // ignored after an issue (shadow length + the exit edge).
    typedef struct packed {
        bit          pend;
        logic [1:0]  psel;
        logic [31:0] ptgt;
        int          quiet;
        logic [1:0]  sel;
        logic [31:0] pc;
        bit          vld;
        int          nredir;
        int          ndefer;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(input mdl_t m, input int shadow, input int cmax,
                                      input bit rst, input bit st, input bit br,
                                      input logic [31:0] bt, input logic [1:0] j,
                                      input logic [31:0] jt, input logic [31:0] jrt);
        mdl_t        n;
        bit          has, fire;
        logic [1:0]  wsel, isel;
        logic [31:0] wtgt, itgt;
        n = m;
        n.vld = 0; n.sel = 2'b00; n.pc = 32'h0;
        if (rst) begin
            n = '0;
            return n;
        end
        has = 1; wsel = 2'b00; wtgt = 32'h0;
        if (br)             begin wsel = 2'b01; wtgt = bt;  end
        else if (j == 2'b10) begin wsel = 2'b10; wtgt = jrt; end
        else if (j == 2'b01) begin wsel = 2'b01; wtgt = jt;  end
        else has = 0;
        fire = 0; isel = wsel; itgt = wtgt;
        if (m.pend) begin
            if (!st) begin fire = 1; isel = m.psel; itgt = m.ptgt; n.pend = 0; end
        end else if (m.quiet > 0) begin
            if (m.quiet == 1) n.quiet = 0;
            else if (!st)     n.quiet = m.quiet - 1;
        end else if (has) begin
            if (st) begin
                n.pend = 1; n.psel = wsel; n.ptgt = wtgt;
                if (n.ndefer < cmax) n.ndefer = n.ndefer + 1;
            end else begin
                fire = 1;
            end
        end
        if (fire) begin
            n.vld = 1; n.sel = isel; n.pc = itgt;
            n.quiet = (shadow > 0) ? shadow + 1 : 0;
            if (n.nredir < cmax) n.nredir = n.nredir + 1;
        end
        return n;
    endfunction

    task automatic check_outs(input string p, input mdl_t m, input logic [3:0] fall,
                              input logic [1:0] sel, input logic [31:0] pc, input logic vld,
                              input logic [3:0] fl, input logic busy);
        check({p, "_sel"},   64'(sel),  64'(m.sel));
        check({p, "_pc"},    64'(pc),   64'(m.pc));
        check({p, "_vld"},   64'(vld),  64'(m.vld));
        check({p, "_flush"}, 64'(fl),   64'(m.vld ? fall : 4'b0000));
        check({p, "_busy"},  64'(busy), 64'(m.pend || (m.quiet > 0)));
    endtask

    task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                        input logic [1:0] j, input logic [31:0] jt, input logic [31:0] jrt);
        reset = rst; stall_i = st; branch_i = br; branch_tgt_i = bt;
        jump_i = j; jal_tgt_i = jt; jalr_tgt_i = jrt;
        @(posedge clock);
        ma = mdl_step(ma, 2, 65535, rst, st, br, bt, j, jt, jrt);
        mb = mdl_step(mb, 0, 3,     rst, st, br, bt, j, jt, jrt);
        @(negedge clock);
        check_outs("a", ma, 4'b0011, a_sel, a_pc, a_vld, {2'b00, a_flush}, a_busy);
        check_outs("b", mb, 4'b0111, b_sel, b_pc, b_vld, {1'b0, b_flush}, b_busy);
`ifdef BRANCH_STATS_EN
        check("a_sredir", 64'(a_sredir), 64'(ma.nredir));
        check("a_sdefer", 64'(a_sdefer), 64'(ma.ndefer));
        check("b_sredir", 64'(b_sredir), 64'(mb.nredir));
        check("b_sdefer", 64'(b_sdefer), 64'(mb.ndefer));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        ma = '0; mb = '0;
        // Reset state
        step(1, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        check("rst_vld", 64'(a_vld), 64'd0);
        check("rst_pc",  64'(a_pc),  64'd0);
        idle(2);

        // Branch only
        step(0, 0, 1, 32'h0000_0100, 2'b00, 32'h0, 32'h0);
        check("br_sel",   64'(a_sel),   64'd1);
        check("br_pc",    64'(a_pc),    64'h100);
        check("br_flush", 64'(a_flush), 64'h3);
        idle(1);
        check("br_once",  64'(a_vld),   64'd0);
        idle(3);

        // Priority: branch beats JALR in the same cycle
        step(0, 0, 1, 32'h200, 2'b10, 32'h0, 32'h300);
        check("prio_pc",  64'(a_pc),  64'h200);
        check("prio_sel", 64'(a_sel), 64'd1);
        idle(1);
        check("prio_once", 64'(a_vld), 64'd0);
        idle(3);

        // Stall deferral: JALR under stall, branch pulsed mid-stall
        step(0, 1, 0, 32'h0,   2'b10, 32'h0, 32'h400);
        check("dfr_busy1", 64'(a_busy), 64'd1);
        step(0, 1, 1, 32'h500, 2'b10, 32'h0, 32'h400);
        step(0, 1, 0, 32'h0,   2'b10, 32'h0, 32'h400);
        check("dfr_busy3", 64'(a_busy), 64'd1);
        check("dfr_novld", 64'(a_vld),  64'd0);
        step(0, 0, 0, 32'h0,   2'b00, 32'h0, 32'h0);
        check("dfr_sel", 64'(a_sel), 64'd2);
        check("dfr_pc",  64'(a_pc),  64'h400);
        idle(4);

        // Shadow window: continuous JAL requests; only the 1st and 5th issue on dut_a
        step(0, 0, 0, 32'h0, 2'b01, 32'h80, 32'h0);
        check("shd_pc0", 64'(a_pc), 64'h80);
        step(0, 0, 0, 32'h0, 2'b01, 32'h84, 32'h0);
        check("shd_drop1", 64'(a_vld), 64'd0);
        check("shd_b_acc", 64'(b_pc),  64'h84);
        step(0, 0, 0, 32'h0, 2'b01, 32'h88, 32'h0);
        check("shd_drop2", 64'(a_vld), 64'd0);
        step(0, 0, 0, 32'h0, 2'b01, 32'h8c, 32'h0);
        check("shd_drop3", 64'(a_vld), 64'd0);
        step(0, 0, 0, 32'h0, 2'b01, 32'h90, 32'h0);
        check("shd_acc", 64'(a_pc), 64'h90);
        idle(4);

        // Reset mid-PENDING discards the captured request
        step(0, 1, 0, 32'h0, 2'b01, 32'h600, 32'h0);
        step(1, 1, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        check("rp_busy", 64'(a_busy), 64'd0);
        step(0, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        check("rp_novld", 64'(a_vld), 64'd0);
        idle(2);

`ifdef BRANCH_STATS_EN
        // Statistics: 3 direct + 1 deferred issues, then a 5th for saturation
        step(1, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 32'h1000 + 32'(k), 2'b00, 32'h0, 32'h0);
            idle(4);
        end
        step(0, 1, 1, 32'h2000, 2'b00, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        idle(4);
        check("st_redir", 64'(a_sredir), 64'd4);
        check("st_defer", 64'(a_sdefer), 64'd1);
        step(0, 0, 1, 32'h3000, 2'b00, 32'h0, 32'h0);
        idle(4);
        check("st_sat", 64'(b_sredir), 64'd3);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 20),
                 $urandom,
                 2'($urandom_range(0, 3)),
                 $urandom,
                 $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
